round_robin_mux_4_to_1: RTL and testbench
=========================================

Name: round_robin_mux_4_to_1

Overview:
- Gathers four independent 1-to-N-bit source channels onto one shared output line. Pairs with the 1-to-4 demultiplexer at the far end.
- Each output beat carries a 2-bit select tag naming the source channel, so the downstream demux drives `select_lines` directly from it.
- Fair round-robin arbitration between channels, with valid/ready handshakes on both sides.
- A registered single-entry output buffer gives full throughput under backpressure.

Parameters:
- WIDTH, 1, data width of each input channel and of the output.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_0, in_1, in_2, in_3  input  WIDTH each  channel data
- valid_0, valid_1, valid_2, valid_3  input  1 each  channel data valid
- ready_0, ready_1, ready_2, ready_3  output  1 each  channel data accepted this cycle (combinational)
- out  output  WIDTH  muxed data (registered)
- select_lines  output  2  source channel index of `out` (registered)
- out_valid  output  1  `out`/`select_lines` hold a beat (registered)
- out_ready  input  1  downstream accepts beat

Behaviour:
- Reset is synchronous and active-high.
  - While reset is high at a clk edge: out=0, select_lines=2'b00, out_valid=0, rr pointer=0.
  - ready_0..3 are forced to 0 while reset is high.
- Load enable: load_en = !out_valid || out_ready.
  - The buffer accepts a new beat when empty, or when it is being drained in the same cycle (simultaneous drain+load allowed; no bubble).
- Arbitration (combinational):
  - Search channels in order ptr, ptr+1, ptr+2, ptr+3, with indices mod 4.
  - Grant goes to the first channel with valid_i=1.
  - The grant exists only if at least one valid is high.
- ready_i = grant_i && load_en && !reset. At most one ready is high per cycle.
- A transfer on channel i occurs when valid_i && ready_i. On the next edge:
  - out <= in_i, select_lines <= i, out_valid <= 1.
  - ptr <= (i+1) mod 4. The 2-bit wrap from 3 goes to 0.
- No grant while load_en is high: if out_ready is high, out_valid <= 0. out and select_lines keep their last values.
- Backpressure: while out_valid && !out_ready, out/select_lines/out_valid are held stable and all ready_i=0. Sources must hold their data.
- Latency: 1 clk from input handshake to out_valid. Throughput: 1 beat/clk when out_ready is held high.
- ptr changes only on a successful input transfer, never on idle cycles.
- Fairness: with all four valids continuously high, grants are issued 0,1,2,3,0,... Any waiting channel is granted within 4 transfers.
- Sources may drop valid without a handshake; there is no requirement to hold.
- Reset mid-operation: a pending out beat is discarded and out_valid=0 on the next edge. Arbitration restarts at channel 0.
- out and select_lines change only on an input transfer or on reset.

Test Plan:
- Reset: assert reset 2 cycles with all valid_i=1, out_ready=1 -> out_valid=0, select_lines=00, out=0, ready_0..3=0 throughout.
- Single source, WIDTH=1: valid_2=1, in_2=1, out_ready=1 from reset release -> ready_2=1 every cycle; one cycle later out=1, select_lines=10, out_valid=1 each cycle; ready_0/1/3=0.
- Round-robin: all valid=1, in_i=i (WIDTH=2), out_ready=1 -> select_lines sequence 00,01,10,11,00 on consecutive cycles, with out equal to select_lines.
- Backpressure: out holds beat from channel 1 while out_ready=0 for 3 cycles -> out/select_lines stable, ready_0..3=0. On the out_ready=1 cycle, channel 2 (next after 1) is loaded with no bubble.
- Sparse pointer: ptr=3 after granting channel 2; only valid_0 and valid_1 high -> channel 0 granted, then channel 1. After the burst, valids drop and out_valid falls to 0 one cycle after the last drain.
- Reset mid-stream: reset=1 while out_valid=1 and out_ready=0 -> next edge out_valid=0. After release with valid_1 and valid_3 high, channel 1 is granted first (ptr=0).

Source files
------------

// File: rtl/round_robin_mux_4_to_1.sv
// Four-channel round-robin multiplexer with a registered single-entry output
// buffer. Each output beat carries the 2-bit index of its source channel.

// Per-channel handshake: a lane is ready only when it holds the grant and the
// output buffer can take a beat this cycle.
module rr_mux_lane (
  input  logic grant,
  input  logic load_en,
  input  logic reset,
  input  logic valid,
  output logic ready,
  output logic xfer
);
  assign ready = grant && load_en && !reset;
  assign xfer  = valid && ready;
endmodule

module round_robin_mux_4_to_1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [WIDTH-1:0] in_3,
  input  logic             valid_0,
  input  logic             valid_1,
  input  logic             valid_2,
  input  logic             valid_3,
  output logic             ready_0,
  output logic             ready_1,
  output logic             ready_2,
  output logic             ready_3,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       select_lines,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][WIDTH-1:0] in_vec;
  logic [NUM_LANES-1:0]            valid_vec;
  logic [NUM_LANES-1:0]            grant_vec;
  logic [NUM_LANES-1:0]            ready_vec;
  logic [NUM_LANES-1:0]            xfer_vec;
  logic [1:0]                      ptr;
  logic [1:0]                      grant_idx;
  logic [1:0]                      idx;
  logic                            grant_any;
  logic                            load_en;
  logic                            xfer;

  assign in_vec    = {in_3, in_2, in_1, in_0};
  assign valid_vec = {valid_3, valid_2, valid_1, valid_0};

  // Buffer takes a beat when empty or when drained in the same cycle.
  assign load_en = !out_valid || out_ready;

  // Rotating priority search starting at ptr; first valid channel wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 2'd0;
    idx       = 2'd0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = ptr + 2'(k);
      if (!grant_any && valid_vec[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
    grant_vec = grant_any ? (4'b0001 << grant_idx) : 4'b0000;
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    rr_mux_lane u_lane (
      .grant   (grant_vec[g]),
      .load_en (load_en),
      .reset   (reset),
      .valid   (valid_vec[g]),
      .ready   (ready_vec[g]),
      .xfer    (xfer_vec[g])
    );
  end

  assign {ready_3, ready_2, ready_1, ready_0} = ready_vec;
  assign xfer = |xfer_vec;

  // Output buffer and pointer: load on transfer, empty on drain without
  // refill; the pointer advances only past a channel that actually moved.
  always_ff @(posedge clk) begin
    if (reset) begin
      out          <= '0;
      select_lines <= 2'b00;
      out_valid    <= 1'b0;
      ptr          <= 2'd0;
    end else if (xfer) begin
      out          <= in_vec[grant_idx];
      select_lines <= grant_idx;
      out_valid    <= 1'b1;
      ptr          <= grant_idx + 2'd1;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_round_robin_mux_4_to_1.sv
// Randomized + directed bench: a queue-based reference model predicts each
// cycle's grant and the beats entering the output buffer; a monitor on the
// falling edge compares the DUT against it.
module tb_round_robin_mux_4_to_1;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_0, in_1, in_2, in_3;
  logic         valid_0, valid_1, valid_2, valid_3;
  logic         ready_0, ready_1, ready_2, ready_3;
  logic [W-1:0] out;
  logic [1:0]   select_lines;
  logic         out_valid;
  logic         out_ready;

  always #5 clk = ~clk;

  round_robin_mux_4_to_1 #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
    .valid_0(valid_0), .valid_1(valid_1), .valid_2(valid_2), .valid_3(valid_3),
    .ready_0(ready_0), .ready_1(ready_1), .ready_2(ready_2), .ready_3(ready_3),
    .out(out), .select_lines(select_lines), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  typedef struct packed {
    logic [1:0]   sel;
    logic [W-1:0] data;
  } beat_t;

  int tests = 0;
  int fails = 0;
  bit done  = 0;

  // Reference model state
  int           m_ptr = 0;
  bit           m_ov  = 0;
  logic [W-1:0] m_out = '0;
  logic [1:0]   m_sel = 2'b00;
  logic [3:0]   exp_ready = 4'b0000;
  int           exp_g = -1;
  beat_t        sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input bit r, input logic [3:0] v, input bit ordy);
    reset = r;
    {valid_3, valid_2, valid_1, valid_0} = v;
    out_ready = ordy;
  endtask

  // One clock: predict this cycle's handshake from current inputs, then
  // advance the model across the edge.
  task automatic step();
    logic [3:0]   vv;
    logic [W-1:0] iv[4];
    bit           ld;
    beat_t        b;
    vv = {valid_3, valid_2, valid_1, valid_0};
    iv[0] = in_0; iv[1] = in_1; iv[2] = in_2; iv[3] = in_3;
    ld = !m_ov || out_ready;
    exp_g = -1;
    for (int k = 0; k < 4; k++)
      if (exp_g < 0 && vv[(m_ptr + k) % 4]) exp_g = (m_ptr + k) % 4;
    exp_ready = (exp_g >= 0 && ld && !reset) ? (4'b0001 << exp_g) : 4'b0000;
    @(posedge clk);
    if (reset) begin
      m_ov = 0; m_out = '0; m_sel = 2'b00; m_ptr = 0;
      sb.delete();
    end else if (exp_ready != 0) begin
      b.sel  = 2'(exp_g);
      b.data = iv[exp_g];
      m_out  = b.data;
      m_sel  = b.sel;
      m_ov   = 1;
      m_ptr  = (exp_g + 1) % 4;
      sb.push_back(b);
    end else if (out_ready) begin
      m_ov = 0;
    end
    #1;
  endtask

  // Monitor: compare handshakes, buffer state and drained beats.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (!done) begin
        chk("ready", {28'd0, ready_3, ready_2, ready_1, ready_0}, {28'd0, exp_ready});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        chk("out", 32'(out), 32'(m_out));
        chk("select_lines", {30'd0, select_lines}, {30'd0, m_sel});
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
          end else begin
            b = sb.pop_front();
            chk("beat_data", 32'(out), 32'(b.data));
            chk("beat_sel", {30'd0, select_lines}, {30'd0, b.sel});
          end
        end
      end
    end
  end

  initial begin
    in_0 = 2'd0; in_1 = 2'd1; in_2 = 2'd2; in_3 = 2'd3;
    // Reset with everything requesting
    set_in(1, 4'b1111, 1);
    repeat (2) step();
    // Single source on channel 2
    in_2 = 2'd1;
    set_in(0, 4'b0100, 1);
    repeat (4) step();
    // Round-robin from ptr=0 with in_i = i
    in_2 = 2'd2;
    set_in(1, 4'b1111, 1); step();
    set_in(0, 4'b1111, 1);
    repeat (6) step();
    // Backpressure: hold for 3 cycles, then drain+load without a bubble
    set_in(0, 4'b1111, 0);
    repeat (3) step();
    set_in(0, 4'b1111, 1);
    repeat (2) step();
    // Sparse pointer: only channels 0 and 1 request, then go idle
    set_in(0, 4'b0011, 1);
    repeat (3) step();
    set_in(0, 4'b0000, 1);
    repeat (3) step();
    // Reset mid-stream with a pending beat under backpressure
    set_in(0, 4'b1111, 0); step();
    step();
    set_in(1, 4'b1111, 0); step();
    set_in(0, 4'b1010, 1);
    repeat (4) step();
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_0 = W'($urandom); in_1 = W'($urandom);
      in_2 = W'($urandom); in_3 = W'($urandom);
      set_in($urandom_range(0, 49) == 0, 4'($urandom), $urandom_range(0, 9) < 7);
      step();
    end
    // Drain everything
    set_in(0, 4'b0000, 1);
    repeat (3) step();
    done = 1;
    chk("sb_drained", sb.size(), 32'd0);
    chk("final_out_valid", {31'd0, out_valid}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
